// File: rtl/tia_playfield_decoder.sv
// tia_playfield_decoder
//   Recovers the six playfield registers (PF0/PF1/PF2 for the left and right
//   screen halves) from a serial playfield pixel stream. Each playfield bit
//   covers four consecutive pixels. The first pixel of a group sets the bit
//   value. The other three pixels only check that the group is uniform.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   line_start  one-cycle pulse; a pixel valid in the same cycle is pixel 0
//   pix_valid   a visible pixel is present on pf this cycle
//   pf          serial playfield pixel (1 = playfield colour)
//   ref_bar     reflect control, active-low, sampled on pixel 80
//   pf0_left .. pf2_right  decoded registers, held between line_done pulses
//   line_done   one-cycle pulse, high while the freshly loaded outputs appear
//   glitch      last completed line contained a non-uniform 4-pixel group
//   busy        capture in progress
module tia_playfield_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_start,
  input  logic       pix_valid,
  input  logic       pf,
  input  logic       ref_bar,
  output logic [7:0] pf0_left,
  output logic [7:0] pf1_left,
  output logic [7:0] pf2_left,
  output logic [7:0] pf0_right,
  output logic [7:0] pf1_right,
  output logic [7:0] pf2_right,
  output logic       line_done,
  output logic       glitch,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_base;
  logic [7:0]  w_cnt_nxt;
  logic        r_bit;
  logic        w_bit_nxt;
  logic        r_glitch_line;
  logic        w_glitch_nxt;
  logic [39:0] r_line;
  logic [39:0] w_line_nxt;
  logic        r_ref;
  logic        w_ref_nxt;
  logic        w_take;
  logic        w_last;
  logic [1:0]  w_sub;
  logic [5:0]  w_k;
  logic [23:0] w_map_left;
  logic [23:0] w_map_right;

  // Maps 20 half-line bits (index 0 = leftmost on screen) to {PF0, PF1, PF2}.
  // The straight order matches the TIA scan order: PF0 4..7, PF1 7..0, PF2 0..7.
  // The reflected order is the mirror image of the straight order.
  function automatic logic [23:0] map_half(input logic [19:0] h,
                                           input logic        straight);
    logic [7:0] p0;
    logic [7:0] p1;
    logic [7:0] p2;
    if (straight) begin
      p0 = {h[3], h[2], h[1], h[0], 4'b0000};
      p1 = {h[4], h[5], h[6], h[7], h[8], h[9], h[10], h[11]};
      p2 = h[19:12];
    end else begin
      p2 = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
      p1 = h[15:8];
      p0 = {h[16], h[17], h[18], h[19], 4'b0000};
    end
    return {p0, p1, p2};
  endfunction

  // line_start restarts a capture from any state. This covers a start from
  // IDLE, an abort during CAPTURE and a back-to-back line from DONE.
  always_comb begin
    w_cnt_base   = line_start ? 8'd0 : r_cnt;
    w_take       = pix_valid && (line_start || (r_state == CAPTURE));
    w_sub        = w_cnt_base[1:0];
    w_k          = w_cnt_base[7:2];
    w_cnt_nxt    = w_cnt_base;
    w_bit_nxt    = r_bit;
    w_glitch_nxt = line_start ? 1'b0 : r_glitch_line;
    w_line_nxt   = r_line;
    w_ref_nxt    = r_ref;
    w_last       = 1'b0;

    if (w_take) begin
      if (w_sub == 2'd0)
        w_bit_nxt = pf;
      else if (pf != r_bit)
        w_glitch_nxt = 1'b1;
      // The group value was latched on sub-position 0, so commit r_bit.
      if ((w_sub == 2'd3) && (w_k < 6'd40))
        w_line_nxt[w_k] = r_bit;
      if (w_cnt_base == 8'd80)
        w_ref_nxt = ref_bar;
      w_cnt_nxt = w_cnt_base + 8'd1;
      w_last    = (w_cnt_base == 8'd159);
    end

    if (line_start) begin
      w_state_nxt = CAPTURE;
    end else begin
      case (r_state)
        CAPTURE: w_state_nxt = w_last ? DONE : CAPTURE;
        default: w_state_nxt = IDLE;
      endcase
    end

    w_map_left  = map_half(w_line_nxt[19:0], 1'b1);
    w_map_right = map_half(w_line_nxt[39:20], w_ref_nxt);
  end

  // The outputs load on the edge that enters DONE. This edge also commits
  // pixel 159. As a result, line_done and the new values appear together
  // during the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_bit         <= 1'b0;
      r_glitch_line <= 1'b0;
      r_line        <= 40'd0;
      r_ref         <= 1'b0;
      line_done     <= 1'b0;
      glitch        <= 1'b0;
      pf0_left      <= 8'd0;
      pf1_left      <= 8'd0;
      pf2_left      <= 8'd0;
      pf0_right     <= 8'd0;
      pf1_right     <= 8'd0;
      pf2_right     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit         <= w_bit_nxt;
      r_glitch_line <= w_glitch_nxt;
      r_line        <= w_line_nxt;
      r_ref         <= w_ref_nxt;
      line_done     <= w_last;
      if (w_last) begin
        {pf0_left, pf1_left, pf2_left}    <= w_map_left;
        {pf0_right, pf1_right, pf2_right} <= w_map_right;
        glitch                            <= w_glitch_nxt;
      end
    end
  end

  assign busy = (r_state == CAPTURE);

endmodule

// File: tb/tb_tia_playfield_decoder.sv
module tb_tia_playfield_decoder;

  logic       clock;
  logic       reset;
  logic       line_start;
  logic       pix_valid;
  logic       pf;
  logic       ref_bar;
  logic [7:0] pf0_left, pf1_left, pf2_left;
  logic [7:0] pf0_right, pf1_right, pf2_right;
  logic       line_done;
  logic       glitch;
  logic       busy;

  tia_playfield_decoder dut (
    .clock     (clock),
    .reset     (reset),
    .line_start(line_start),
    .pix_valid (pix_valid),
    .pf        (pf),
    .ref_bar   (ref_bar),
    .pf0_left  (pf0_left),
    .pf1_left  (pf1_left),
    .pf2_left  (pf2_left),
    .pf0_right (pf0_right),
    .pf1_right (pf1_right),
    .pf2_right (pf2_right),
    .line_done (line_done),
    .glitch    (glitch),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] p0l, p1l, p2l, p0r, p1r, p2r;
    logic       g;
  } exp_t;

  typedef struct {
    int   lo0, hi0, lo1, hi1, flip;
    bit   rb;
    bit   gaps;
    exp_t e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   pending_done = 0;
  exp_t q[$];
  exp_t last_exp;
  vec_t tv[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(int lo0, int hi0, int lo1, int hi1, int flip, bit rb, bit gaps,
                              logic [7:0] p0l, logic [7:0] p1l, logic [7:0] p2l,
                              logic [7:0] p0r, logic [7:0] p1r, logic [7:0] p2r, logic g);
    vec_t v;
    v.lo0 = lo0; v.hi0 = hi0; v.lo1 = lo1; v.hi1 = hi1; v.flip = flip;
    v.rb = rb; v.gaps = gaps;
    v.e = '{p0l: p0l, p1l: p1l, p2l: p2l, p0r: p0r, p1r: p1r, p2r: p2r, g: g};
    return v;
  endfunction

  function automatic bit pix_val(vec_t v, int p);
    return (((p >= v.lo0) && (p <= v.hi0)) || ((p >= v.lo1) && (p <= v.hi1))) ^ (p == v.flip);
  endfunction

  // Scoreboard: every line_done pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && line_done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_line_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pf0_left",  pf0_left,  e.p0l);
        chk("pf1_left",  pf1_left,  e.p1l);
        chk("pf2_left",  pf2_left,  e.p2l);
        chk("pf0_right", pf0_right, e.p0r);
        chk("pf1_right", pf1_right, e.p1r);
        chk("pf2_right", pf2_right, e.p2r);
        chk("glitch",    glitch,    e.g);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (pending_done) begin
      chk("line_done_timing", line_done, 1);
      pending_done = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      line_start = 0; pix_valid = 0;
      pf = 1'($urandom_range(1, 0)); ref_bar = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic drive_line(input vec_t v);
    q.push_back(v.e);
    for (int p = 0; p < 160; p++) begin
      tick();
      if (p == 40) chk("busy_capture", busy, 1);
      line_start = (p == 0);
      pix_valid  = 1;
      pf         = pix_val(v, p);
      ref_bar    = (p == 80) ? v.rb : ~v.rb;
      if (v.gaps && p < 159) begin
        tick();
        line_start = 0; pix_valid = 0; pf = ~pf;
        ref_bar = 1'($urandom_range(1, 0));
      end
    end
    pending_done = 1;
    last_exp = v.e;
  endtask

  // Partial line with non-uniform groups; never reaches line_done.
  task automatic partial(input int n);
    for (int p = 0; p < n; p++) begin
      tick();
      line_start = (p == 0);
      pix_valid  = 1;
      pf         = (p % 3 != 1);
      ref_bar    = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tv[0] = mk(0, 15, -1, -2, -1, 1, 0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tv[1] = mk(16, 19, 96, 99, -1, 1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 0);
    tv[2] = mk(16, 19, 96, 99, -1, 0, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h08, 0);
    tv[3] = mk(16, 19, -1, -2, 17, 1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    tv[4] = mk(16, 19, -1, -2, -1, 1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tv[5] = mk(0, 15, -1, -2, -1, 1, 1, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tv[6] = mk(0, 159, -1, -2, -1, 1, 0, 8'hF0, 8'hFF, 8'hFF, 8'hF0, 8'hFF, 8'hFF, 0);
    tv[7] = mk(144, 159, -1, -2, -1, 0, 0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 0);
    tv[8] = mk(0, 159, -1, -2, -1, 0, 0, 8'hF0, 8'hFF, 8'hFF, 8'hF0, 8'hFF, 8'hFF, 0);

    reset = 1; line_start = 0; pix_valid = 0; pf = 0; ref_bar = 1;
    repeat (3) @(negedge clock);
    chk("rst_pf0_left", pf0_left, 0);
    chk("rst_pf1_left", pf1_left, 0);
    chk("rst_pf2_left", pf2_left, 0);
    chk("rst_pf0_right", pf0_right, 0);
    chk("rst_pf1_right", pf1_right, 0);
    chk("rst_pf2_right", pf2_right, 0);
    chk("rst_glitch", glitch, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_busy", busy, 0);
    reset = 0;

    // Pixels in IDLE without line_start are ignored.
    for (int i = 0; i < 5; i++) begin
      tick();
      pix_valid = 1; pf = 1;
    end
    tick();
    chk("idle_pix_busy", busy, 0);
    pix_valid = 0;

    // Rows 6 -> 7 run back to back: line_start lands in the DONE cycle.
    for (int i = 0; i < 9; i++) begin
      drive_line(tv[i]);
      if (i != 6) idle(2);
    end
    chk("idle_busy", busy, 0);

    // Abort at pixel 50, then a full line.
    d0 = done_cnt;
    partial(50);
    chk("hold_pf1_left", pf1_left, last_exp.p1l);
    chk("hold_pf0_right", pf0_right, last_exp.p0r);
    chk("abort_busy", busy, 1);
    drive_line(tv[0]);
    idle(3);
    chk("abort_done_count", done_cnt, d0 + 1);

    // Reset mid-line at pixel 100.
    partial(101);
    #2 reset = 1;
    #1;
    chk("mid_rst_pf0_left", pf0_left, 0);
    chk("mid_rst_pf1_left", pf1_left, 0);
    chk("mid_rst_pf2_left", pf2_left, 0);
    chk("mid_rst_pf0_right", pf0_right, 0);
    chk("mid_rst_glitch", glitch, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_line_done", line_done, 0);
    @(negedge clock);
    reset = 0; line_start = 0; pix_valid = 0;
    d0 = done_cnt;
    idle(5);
    chk("no_done_after_reset", done_cnt, d0);
    chk("post_rst_hold", pf0_left, 0);
    drive_line(tv[1]);
    idle(3);
    chk("post_rst_done_count", done_cnt, d0 + 1);

    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
